// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Purpose  : Serializes bitstream words LSB-first into a configuration DFF
//            chain, gating its prog_clk through a registered enable. An
//            optional verify pass compares the chain tail against the
//            re-sent stream and records the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int IDX_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  err_idx
);

  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  localparam logic [IDX_W-1:0] c_NWORDS    = IDX_W'(NWORDS);
  localparam logic [IDX_W-1:0] c_CHAIN_LEN = IDX_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] c_WORD_W    = CNT_W'(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state,     w_state_nxt;
  logic               r_verify,    w_verify_nxt;
  logic [WORD_W-1:0]  r_buf,       w_buf_nxt;
  logic [CNT_W-1:0]   r_buf_cnt,   w_buf_cnt_nxt;   // bits buffered, not yet presented
  logic [IDX_W-1:0]   r_acc_bits,  w_acc_bits_nxt;  // bits taken in from accepted words
  logic [IDX_W-1:0]   r_words,     w_words_nxt;     // words accepted this pass
  logic [IDX_W-1:0]   r_bit_idx,   w_bit_idx_nxt;   // bits presented to the chain
  logic               r_head,      w_head_nxt;
  logic               r_shift_en,  w_shift_en_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_done,      w_done_nxt;
  logic               r_err,       w_err_nxt;
  logic [IDX_W-1:0]   r_err_idx,   w_err_idx_nxt;

  logic               w_ready;
  logic               w_accept;
  logic [IDX_W-1:0]   w_remain;
  logic [CNT_W-1:0]   w_load_cnt;

  // Ready only from state and counters; the reload may overlap the last buffered bit.
  assign w_ready    = (r_state == S_SHIFT) && (r_buf_cnt <= CNT_W'(1)) && (r_words < c_NWORDS);
  assign w_accept   = cfg_valid && w_ready && !abort;
  // The final word may carry fewer useful bits than WORD_W; the rest are dropped.
  assign w_remain   = c_CHAIN_LEN - r_acc_bits;
  assign w_load_cnt = (int'(w_remain) >= WORD_W) ? c_WORD_W : CNT_W'(w_remain);

  assign cfg_ready     = w_ready;
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign err_idx       = r_err_idx;

  // State and datapath registers.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_state    <= S_IDLE;
      r_verify   <= 1'b0;
      r_buf      <= '0;
      r_buf_cnt  <= '0;
      r_acc_bits <= '0;
      r_words    <= '0;
      r_bit_idx  <= '0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_idx  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_verify   <= w_verify_nxt;
      r_buf      <= w_buf_nxt;
      r_buf_cnt  <= w_buf_cnt_nxt;
      r_acc_bits <= w_acc_bits_nxt;
      r_words    <= w_words_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_head     <= w_head_nxt;
      r_shift_en <= w_shift_en_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_idx  <= w_err_idx_nxt;
    end
  end

  // Next-state: pass sequencing, bit emission and tail comparison.
  always_comb begin
    w_state_nxt    = r_state;
    w_verify_nxt   = r_verify;
    w_buf_nxt      = r_buf;
    w_buf_cnt_nxt  = r_buf_cnt;
    w_acc_bits_nxt = r_acc_bits;
    w_words_nxt    = r_words;
    w_bit_idx_nxt  = r_bit_idx;
    w_head_nxt     = r_head;
    w_shift_en_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_err_idx_nxt  = r_err_idx;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_SHIFT;
          w_verify_nxt   = verify;
          w_buf_cnt_nxt  = '0;
          w_acc_bits_nxt = '0;
          w_words_nxt    = '0;
          w_bit_idx_nxt  = '0;
          w_busy_nxt     = 1'b1;
          w_done_nxt     = 1'b0;
          w_err_nxt      = 1'b0;
          w_err_idx_nxt  = '0;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          w_state_nxt   = S_IDLE;
          w_buf_cnt_nxt = '0;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b0;
          w_err_nxt     = 1'b1;
        end else begin
          // Emission: a fresh word feeds the head directly when the buffer is empty.
          if (w_accept) begin
            w_words_nxt    = r_words + 1'b1;
            w_acc_bits_nxt = r_acc_bits + IDX_W'(w_load_cnt);
            w_shift_en_nxt = 1'b1;
            if (r_buf_cnt == '0) begin
              w_head_nxt    = cfg_data[0];
              w_buf_nxt     = cfg_data >> 1;
              w_buf_cnt_nxt = w_load_cnt - 1'b1;
            end else begin
              w_head_nxt    = r_buf[0];
              w_buf_nxt     = cfg_data;
              w_buf_cnt_nxt = w_load_cnt;
            end
          end else if (r_buf_cnt != '0) begin
            w_head_nxt     = r_buf[0];
            w_buf_nxt      = r_buf >> 1;
            w_buf_cnt_nxt  = r_buf_cnt - 1'b1;
            w_shift_en_nxt = 1'b1;
          end

          // Presentation: the chain clocks in r_head on this edge.
          if (r_shift_en) begin
            if (r_verify && (ccff_tail != r_head) && !r_err) begin
              w_err_nxt     = 1'b1;
              w_err_idx_nxt = r_bit_idx;
            end
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            if (r_bit_idx == c_LAST_IDX) begin
              w_state_nxt = S_FINISH;
            end
          end
        end
      end

      S_FINISH: begin
        if (abort) begin
          w_state_nxt   = S_IDLE;
          w_buf_cnt_nxt = '0;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b0;
          w_err_nxt     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_chain_loader
// Purpose  : Directed and randomized passes against a 10-DFF chain model
//            for ccff_chain_loader (CHAIN_LEN=10, WORD_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int CL = 10;
    localparam int WW = 4;
    localparam int IW = $clog2(CL + 1);

    logic          prog_clk = 1'b0;
    logic          prog_reset;
    logic          start;
    logic          verify;
    logic          abort;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] err_idx;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .verify        (verify),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_idx       (err_idx)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: chain[0] is the head DFF, chain[CL-1] the tail.
    logic [CL-1:0] chain = '0;
    logic          corrupt_req = 1'b0;
    int            corrupt_pos = 0;

    // Gated chain clock plus a one-shot bit upset used to provoke verify errors.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
        else if (corrupt_req) chain[CL-1-corrupt_pos] <= ~chain[CL-1-corrupt_pos];
    end
    assign ccff_tail = chain[CL-1];

    // What the chain should hold, indexed by stream bit number.
    logic [CL-1:0] loaded = '0;

    task automatic run_pass(input logic vmode, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input logic [WW-1:0] w2, input int stall_mode, input int abort_after,
                            input int restart_at);
        logic [WW-1:0] wv[3];
        logic [CL-1:0] expb;
        logic [CL-1:0] got;
        logic          exp_err;
        logic [IW-1:0] exp_idx;
        logic          accepted;
        logic          aborted;
        int acc, shifts, cyc, first_acc, first_sh, last_sh, gaps, idle_left;
        wv[0] = w0; wv[1] = w1; wv[2] = w2;
        for (int k = 0; k < CL; k++) expb[k] = wv[k / WW][k % WW];
        exp_err = 1'b0;
        exp_idx = '0;
        if (vmode) begin
            for (int k = 0; k < CL; k++) begin
                if (!exp_err && loaded[k] != expb[k]) begin
                    exp_err = 1'b1;
                    exp_idx = IW'(k);
                end
            end
        end
        got = '0;
        acc = 0; shifts = 0; cyc = 0; first_acc = -1; first_sh = -1; last_sh = -1;
        gaps = 0; idle_left = 0; aborted = 1'b0;

        start  = 1'b1;
        verify = vmode;
        @(posedge prog_clk); #1;
        start  = 1'b0;
        verify = 1'($urandom);
        check("busy_after_start", busy, 1'b1);

        while (cyc < 200) begin
            if (idle_left > 0) begin
                cfg_valid = 1'b0;
                if (cfg_ready) idle_left--;
            end else if (acc < 3) begin
                cfg_valid = 1'b1;
                cfg_data  = wv[acc];
            end else if (stall_mode == 0) begin
                cfg_valid = 1'b1;
                cfg_data  = WW'($urandom);
            end else begin
                cfg_valid = 1'b0;
            end
            accepted = cfg_valid && cfg_ready;
            abort    = (shifts == abort_after);
            if (cyc == restart_at) begin
                start  = 1'b1;
                verify = ~vmode;
            end
            @(posedge prog_clk); #1;
            start = 1'b0;
            if (abort) begin
                aborted = 1'b1;
                abort   = 1'b0;
                break;
            end
            if (accepted) begin
                if (first_acc < 0) first_acc = cyc;
                acc++;
                idle_left = (stall_mode == 1) ? 3 : (stall_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            end
            if (ccff_shift_en) begin
                if (shifts < CL) got[shifts] = ccff_head;
                shifts++;
                if (first_sh < 0) first_sh = cyc;
                else if (last_sh != cyc - 1) gaps++;
                last_sh = cyc;
            end
            cyc++;
            if (done) break;
        end
        cfg_valid = 1'b0;

        if (aborted) begin
            check("abort_shift_en", ccff_shift_en, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_err", err, 1'b1);
            check("abort_done", done, 1'b0);
            check("abort_ready", cfg_ready, 1'b0);
        end else begin
            check("pass_completes", done, 1'b1);
            check("accept_count", acc, 3);
            check("shift_count", shifts, CL);
            check("head_sequence", got, expb);
            check("first_shift_latency", first_sh, first_acc);
            if (stall_mode == 0) check("gap_free", gaps, 0);
            if (stall_mode == 1) check("has_gaps", (gaps > 0), 1'b1);
            check("busy_end", busy, 1'b0);
            check("err_end", err, exp_err);
            if (vmode) check("err_idx", err_idx, exp_idx);
            loaded = expb;
            @(posedge prog_clk); #1;
            check("done_held", done, 1'b1);
        end
    endtask

    task automatic flip_bit(input int k);
        corrupt_pos = k;
        corrupt_req = 1'b1;
        @(posedge prog_clk); #1;
        corrupt_req = 1'b0;
        loaded[k] = ~loaded[k];
    endtask

    initial begin
        logic [WW-1:0] r0, r1, r2;
        int fk;
        prog_reset = 1'b1;
        start = 1'b0; verify = 1'b0; abort = 1'b0;
        cfg_data = '0; cfg_valid = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_shift_en", ccff_shift_en, 1'b0);
        check("rst_head", ccff_head, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_idx", err_idx, 4'd0);
        prog_reset = 1'b0;
        @(posedge prog_clk); #1;

        // Directed plan: load, stalled load, clean verify, corrupted verify.
        run_pass(1'b0, 4'hA, 4'h5, 4'h3, 0, -1, -1);
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        check("idle_abort_done", done, 1'b1);
        check("idle_abort_err", err, 1'b0);
        run_pass(1'b0, 4'hA, 4'h5, 4'h3, 1, -1, -1);
        run_pass(1'b1, 4'hA, 4'h5, 4'h3, 0, -1, -1);
        flip_bit(6);
        run_pass(1'b1, 4'hA, 4'h5, 4'h3, 2, -1, -1);

        // Abort after five bits, then a normal load with a start pulse mid-pass.
        run_pass(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 0, 5, -1);
        run_pass(1'b0, 4'hA, 4'h5, 4'h3, 0, -1, 3);

        // Randomized load / verify / corrupted verify rounds.
        for (int i = 0; i < 4; i++) begin
            r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom);
            run_pass(1'b0, r0, r1, r2, 2, -1, -1);
            run_pass(1'b1, r0, r1, r2, 2, -1, -1);
            fk = int'($urandom_range(0, CL - 1));
            flip_bit(fk);
            run_pass(1'b1, r0, r1, r2, 2, -1, -1);
        end

        // Reset pulsed in the middle of a shift pass.
        start = 1'b1; verify = 1'b0;
        @(posedge prog_clk); #1;
        start = 1'b0;
        cfg_valid = 1'b1; cfg_data = 4'hF;
        repeat (4) @(posedge prog_clk);
        #2;
        prog_reset = 1'b1;
        #1;
        check("midrst_shift_en", ccff_shift_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_head", ccff_head, 1'b0);
        check("midrst_ready", cfg_ready, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_done", done, 1'b0);
        @(posedge prog_clk); #2;
        prog_reset = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        check("idle_valid_not_ready", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        run_pass(1'b0, 4'hA, 4'h5, 4'h3, 0, -1, -1);
        run_pass(1'b1, 4'hA, 4'h5, 4'h3, 1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences a fabric configuration chain: a serial DFF shift chain that enters at ccff_head and exits at ccff_tail, clocked by prog_clk.
- Accepts bitstream words over a valid/ready port and serializes them LSB-first onto ccff_head.
- Drives the clock-enable for the chain's prog_clk gate; the chain shifts only on edges where the enable is high.
- Optional verify pass: the same bitstream is re-sent, and ccff_tail is compared bit-by-bit against the incoming stream to confirm the loaded contents.

Parameters:
- CHAIN_LEN, 64: total DFF count in the chain (≥1).
- WORD_W, 8: bitstream word width (≥2).
- IDX_W, $clog2(CHAIN_LEN+1): width of the bit index and error index.

Ports:
- prog_clk  in  1  configuration clock.
- prog_reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- verify  in  1  pass mode, latched with start (0 = load, 1 = verify).
- abort  in  1  synchronous abort of the current pass.
- cfg_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid && cfg_ready.
- ccff_head  out  1  serial data to the chain head (registered).
- ccff_shift_en  out  1  chain clock enable (registered).
- ccff_tail  in  1  serial data from the chain tail.
- busy  out  1  pass in progress.
- done  out  1  last pass completed; held until the next start.
- err  out  1  verify mismatch or abort; held until the next start.
- err_idx  out  IDX_W  bit index of the first mismatch.

Behaviour:
- Reset (asynchronous, any state): state = IDLE. All outputs are 0: cfg_ready, ccff_head, ccff_shift_en, busy, done, err, err_idx. Internal counters are cleared.
- Reset mid-pass: chain contents are undefined; the host must restart.
- States:
  - IDLE: on start, latch verify, clear done/err/err_idx/bit_idx/buf_cnt, set busy, go to SHIFT.
  - SHIFT → FINISH after the CHAIN_LEN-th bit is presented.
  - FINISH: set done, clear busy, go to IDLE.
- start is ignored while busy.
- Word buffer: buf_cnt = number of bits buffered but not yet presented.
- cfg_ready = (state == SHIFT) && (buf_cnt ≤ 1) && (words_accepted < ceil(CHAIN_LEN/WORD_W)). cfg_ready is combinational from state and counters only.
- On accept, buf_cnt is loaded with min(WORD_W, CHAIN_LEN − bits already accepted). Unused high bits of the final word are discarded.
- Bit emission: each cycle in SHIFT with buf_cnt > 0 (counting a word accepted that cycle):
  - next cycle ccff_head = next buffered bit and ccff_shift_en = 1;
  - buf_cnt decrements and bit_idx increments.
  - Otherwise ccff_shift_en = 0 and ccff_head holds its value.
- Throughput: with cfg_valid held high, shifting is gap-free — one bit per cycle, with the reload overlapping the last bit.
- Latency: first ccff_shift_en = 1 occurs in the cycle after the first accept.
- ccff_shift_en is high for exactly CHAIN_LEN cycles per completed pass, possibly non-contiguous when cfg_valid stalls.
- Verify compare: at each edge with ccff_shift_en = 1 and verify latched, if ccff_tail != ccff_head and err == 0, set err = 1 and err_idx = index of the bit being presented (0-based).
  - Only the first mismatch is recorded.
  - The pass always runs to completion.
- In load mode, ccff_tail is ignored.
- Abort (any non-IDLE state): the next cycle forces ccff_shift_en = 0, cfg_ready = 0, busy = 0, done = 0, err = 1, state = IDLE. Buffered bits are discarded.
- Abort in IDLE has no effect.
- abort takes priority over the accept/shift in the same cycle.
- CHAIN_LEN < WORD_W: a single word is accepted and only the low CHAIN_LEN bits are shifted.

Test Plan (CHAIN_LEN = 10, WORD_W = 4):
- Load, cfg_valid held high, words 0xA, 0x5, 0x3 → exactly 3 accepts; ccff_shift_en high for 10 consecutive cycles; ccff_head sequence 0,1,0,1,1,0,1,0,1,1; done = 1, busy = 0, err = 0.
- Same load with cfg_valid low for 3 cycles between words → ccff_shift_en has gaps, still totals 10 high cycles; head sequence identical.
- Load then verify with the same words against a 10-DFF chain model → err = 0, done = 1.
- Verify after a load with bit 6 flipped in the model → err = 1, err_idx = 6; pass still completes with done = 1.
- abort asserted after 5 bits → next cycle ccff_shift_en = 0, busy = 0, err = 1, done = 0; a new start then loads normally.
- prog_reset pulsed mid-SHIFT → all outputs 0 immediately; start while busy is ignored; cfg_valid with cfg_ready = 0 is not consumed.
